video_timing_gen: RTL and testbench

//   Source end of the pixel-timing interface (vs/hs/de) used throughout the video path.

---
 rtl/video_timing_pkg.sv | 28 ++
 rtl/timing_axis_counter.sv | 28 ++
 rtl/video_timing_gen.sv | 120 ++++++++++++
 tb/tb_video_timing_gen.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared timing descriptors for the raster generator: standard mode sets,
// total-length helper and counter-width helper.
package video_timing_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } axis_timing_t;

    // Standard CEA/VESA modes, horizontal in clocks and vertical in lines
    localparam axis_timing_t T720P60_H  = '{active: 1280, fp: 110, sync: 40, bp: 220};
    localparam axis_timing_t T720P60_V  = '{active: 720,  fp: 5,   sync: 5,  bp: 20};
    localparam axis_timing_t T1080P60_H = '{active: 1920, fp: 88,  sync: 44, bp: 148};
    localparam axis_timing_t T1080P60_V = '{active: 1080, fp: 4,   sync: 5,  bp: 36};
    localparam axis_timing_t T480P_H    = '{active: 640,  fp: 16,  sync: 96, bp: 48};
    localparam axis_timing_t T480P_V    = '{active: 480,  fp: 10,  sync: 2,  bp: 33};

    function automatic int unsigned timing_total(input axis_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: counts 0..MAX-1 while enabled and flags the wrap cycle,
// which is combinational so the next axis can advance on the same edge.
module timing_axis_counter #(
    parameter int unsigned MAX = 8,
    parameter int unsigned W   = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    assign wrap = en && (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: h/v counters decoded into registered hs/vs/de strobes,
// frame/line markers and active-pixel coordinates, one clock behind the counters.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = T720P60_H.active,
    parameter int unsigned H_FP     = T720P60_H.fp,
    parameter int unsigned H_SYNC   = T720P60_H.sync,
    parameter int unsigned H_BP     = T720P60_H.bp,
    parameter int unsigned V_ACTIVE = T720P60_V.active,
    parameter int unsigned V_FP     = T720P60_V.fp,
    parameter int unsigned V_SYNC   = T720P60_V.sync,
    parameter int unsigned V_BP     = T720P60_V.bp,
    parameter logic        HS_POL   = 1'b1,
    parameter logic        VS_POL   = 1'b1,
    localparam axis_timing_t H_TIMING = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP},
    localparam axis_timing_t V_TIMING = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP},
    localparam int unsigned H_TOTAL = timing_total(H_TIMING),
    localparam int unsigned V_TOTAL = timing_total(V_TIMING),
    localparam int unsigned HW      = cnt_width(H_TOTAL),
    localparam int unsigned VW      = cnt_width(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    output logic          hs_out,
    output logic          vs_out,
    output logic          de_out,
    output logic          sof_out,
    output logic          eol_out,
    output logic [HW-1:0] x_out,
    output logic [VW-1:0] y_out
);

    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    generate
        if (H_ACTIVE == 0 || H_SYNC == 0 || V_ACTIVE == 0 || V_SYNC == 0) begin : g_bad_timing
            $error("video_timing_gen: active and sync lengths must be non-zero");
        end
    endgenerate

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap;
    logic          frame_wrap_unused;

    timing_axis_counter #(.MAX(H_TOTAL), .W(HW)) u_h_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .cnt     (h_cnt),
        .wrap    (h_wrap)
    );

    timing_axis_counter #(.MAX(V_TOTAL), .W(VW)) u_v_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en & h_wrap),
        .cnt     (v_cnt),
        .wrap    (frame_wrap_unused)
    );

    // Compare at 32 bits so window ends equal to the total do not truncate
    logic [31:0] h32;
    logic [31:0] v32;
    assign h32 = 32'(h_cnt);
    assign v32 = 32'(v_cnt);

    logic          hs_next, vs_next, de_next, sof_next, eol_next;
    logic [HW-1:0] x_next;
    logic [VW-1:0] y_next;

    always_comb begin
        de_next  = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
        hs_next  = ((h32 >= HS_START) && (h32 < HS_END)) ? HS_POL : ~HS_POL;
        vs_next  = ((v32 >= VS_START) && (v32 < VS_END)) ? VS_POL : ~VS_POL;
        sof_next = (h_cnt == '0) && (v_cnt == '0);
        eol_next = (h32 == H_ACTIVE - 1) && (v32 < V_ACTIVE);
        x_next   = de_next ? h_cnt : '0;
        y_next   = de_next ? v_cnt : '0;
    end

    logic          hs_reg, vs_reg, de_reg, sof_reg, eol_reg;
    logic [HW-1:0] x_reg;
    logic [VW-1:0] y_reg;

    // Outputs only move with the counters, so a stalled raster holds every strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_reg  <= ~HS_POL;
            vs_reg  <= ~VS_POL;
            de_reg  <= 1'b0;
            sof_reg <= 1'b0;
            eol_reg <= 1'b0;
            x_reg   <= '0;
            y_reg   <= '0;
        end else if (en) begin
            hs_reg  <= hs_next;
            vs_reg  <= vs_next;
            de_reg  <= de_next;
            sof_reg <= sof_next;
            eol_reg <= eol_next;
            x_reg   <= x_next;
            y_reg   <= y_next;
        end
    end

    assign hs_out  = hs_reg;
    assign vs_out  = vs_reg;
    assign de_out  = de_reg;
    assign sof_out = sof_reg;
    assign eol_out = eol_reg;
    assign x_out   = x_reg;
    assign y_out   = y_reg;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on an 8x6 raster, with an active-high
// sync instance (a) and an active-low sync instance (b) driven in parallel.
module tb_video_timing_gen;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = 8, VT = 6;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       sof;
        logic       eol;
        logic [2:0] x;
        logic [2:0] y;
    } obs_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic en = 1'b0;
    logic hs_a, vs_a, de_a, sof_a, eol_a;
    logic hs_b, vs_b, de_b, sof_b, eol_b;
    logic [2:0] x_a, y_a, x_b, y_b;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cycle = 0;
    int   mh = 0;
    int   mv = 0;
    obs_t last_exp = '0;
    obs_t exp_q[$];
    obs_t got_a, got_b, exp;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .en(en),
        .hs_out(hs_a), .vs_out(vs_a), .de_out(de_a), .sof_out(sof_a), .eol_out(eol_a),
        .x_out(x_a), .y_out(y_a)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .en(en),
        .hs_out(hs_b), .vs_out(vs_b), .de_out(de_b), .sof_out(sof_b), .eol_out(eol_b),
        .x_out(x_b), .y_out(y_b)
    );

    // Expected strobes for raster position (h,v) on the 8x6 test raster
    function automatic obs_t decode(input int h, input int v);
        obs_t o;
        o.de  = (h < 4) && (v < 3);
        o.hs  = (h == 5) || (h == 6);
        o.vs  = (v == 4);
        o.sof = (h == 0) && (v == 0);
        o.eol = (h == 3) && (v < 3);
        o.x   = o.de ? 3'(h) : 3'd0;
        o.y   = o.de ? 3'(v) : 3'd0;
        return o;
    endfunction

    function automatic obs_t inv_pol(input obs_t o);
        obs_t r;
        r = o;
        r.hs = ~o.hs;
        r.vs = ~o.vs;
        return r;
    endfunction

    task automatic model_reset();
        mh = 0;
        mv = 0;
        last_exp = '0;
        exp_q.delete();
    endtask

    // One clock of stimulus: push the expected output, clock, sample both DUTs
    task automatic step(input bit e);
        if (e) begin
            last_exp = decode(mh, mv);
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end
        end
        exp_q.push_back(last_exp);
        en = e;
        @(posedge clk);
        #1;
        cycle++;
        got_a = {hs_a, vs_a, de_a, sof_a, eol_a, x_a, y_a};
        got_b = {hs_b, vs_b, de_b, sof_b, eol_b, x_b, y_b};
        exp = exp_q.pop_front();
        $display("cycle %0d en=%0b hs=%0b vs=%0b de=%0b sof=%0b eol=%0b x=%0d y=%0d",
                 cycle, e, hs_a, vs_a, de_a, sof_a, eol_a, x_a, y_a);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({hs_a, vs_a, de_a, sof_a, eol_a, x_a, y_a} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_a: got %h required %h", {hs_a, vs_a, de_a, sof_a, eol_a, x_a, y_a}, 11'd0);
        end
        n_checks++;
        if ({hs_b, vs_b, de_b, sof_b, eol_b, x_b, y_b} !== {2'b11, 9'd0}) begin
            n_fail++;
            $display("FAIL reset_b: got %h required %h", {hs_b, vs_b, de_b, sof_b, eol_b, x_b, y_b}, {2'b11, 9'd0});
        end
        en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_first_line();
        logic [7:0] de_pat;
        int eol_at;
        de_pat = '0;
        eol_at = -1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            n_checks++;
            if (got_a !== exp) begin
                n_fail++;
                $display("FAIL first_line_a cycle %0d: got %h required %h", cycle, got_a, exp);
            end
            if (i == 0) begin
                n_checks++;
                if (got_a !== obs_t'{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0}) begin
                    n_fail++;
                    $display("FAIL first_pixel: got %h required de=1 sof=1 x=0 y=0", got_a);
                end
            end
            de_pat[i] = got_a.de;
            if (got_a.eol) eol_at = i;
        end
        n_checks++;
        if (de_pat !== 8'b0000_1111) begin
            n_fail++;
            $display("FAIL de_pattern: got %b required %b", de_pat, 8'b0000_1111);
        end
        n_checks++;
        if (eol_at != 3) begin
            n_fail++;
            $display("FAIL eol_position: got %0d required 3", eol_at);
        end
    endtask

    task automatic test_hsync();
        logic [7:0] hs_pat;
        int overlap;
        overlap = 0;
        hs_pat = '0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1);
            n_checks++;
            if (got_b !== inv_pol(exp)) begin
                n_fail++;
                $display("FAIL hsync_b cycle %0d: got %h required %h", cycle, got_b, inv_pol(exp));
            end
            hs_pat[i % 8] = got_a.hs;
            if (got_a.hs && got_a.de) overlap++;
            if (i % 8 == 7) begin
                n_checks++;
                if (hs_pat !== 8'b0110_0000) begin
                    n_fail++;
                    $display("FAIL hs_window line %0d: got %b required %b", i / 8 + 1, hs_pat, 8'b0110_0000);
                end
            end
        end
        n_checks++;
        if (overlap != 0) begin
            n_fail++;
            $display("FAIL de_during_hs: got %0d cycles required 0", overlap);
        end
    endtask

    task automatic test_frames();
        int vs_cnt, de_cnt, hs_low_b, vs_low_b, last_sof;
        vs_cnt = 0; de_cnt = 0; hs_low_b = 0; vs_low_b = 0; last_sof = -1;
        for (int i = 0; i < 144; i++) begin
            step(1'b1);
            n_checks++;
            if (got_a !== exp) begin
                n_fail++;
                $display("FAIL frames_a cycle %0d: got %h required %h", cycle, got_a, exp);
            end
            vs_cnt += int'(got_a.vs);
            de_cnt += int'(got_a.de);
            hs_low_b += int'(!got_b.hs);
            vs_low_b += int'(!got_b.vs);
            if (got_a.sof) begin
                if (last_sof >= 0) begin
                    n_checks++;
                    if (cycle - last_sof != 48) begin
                        n_fail++;
                        $display("FAIL sof_period: got %0d required 48", cycle - last_sof);
                    end
                end
                last_sof = cycle;
            end
        end
        n_checks++;
        if (vs_cnt != 24) begin
            n_fail++;
            $display("FAIL vs_cycles: got %0d required 24", vs_cnt);
        end
        n_checks++;
        if (de_cnt != 36) begin
            n_fail++;
            $display("FAIL de_cycles: got %0d required 36", de_cnt);
        end
        n_checks++;
        if (hs_low_b != 36 || vs_low_b != 24) begin
            n_fail++;
            $display("FAIL polarity_b_counts: got hs_low=%0d vs_low=%0d required 36 and 24", hs_low_b, vs_low_b);
        end
    endtask

    task automatic test_pause();
        int sof_cycle;
        bit found;
        sof_cycle = -1;
        found = 1'b0;
        for (int i = 0; i < 11; i++) begin
            step(1'b1);
            if (got_a.sof) sof_cycle = cycle;
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            n_checks++;
            if (got_a !== obs_t'{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 3'd1} || got_a !== exp) begin
                n_fail++;
                $display("FAIL pause_hold %0d: got %h required x=2 y=1 de=1", i, got_a);
            end
        end
        step(1'b1);
        n_checks++;
        if (got_a !== obs_t'{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 3'd1}) begin
            n_fail++;
            $display("FAIL pause_resume: got %h required x=3 y=1 de=1 eol=1", got_a);
        end
        for (int i = 0; i < 60 && !found; i++) begin
            step(1'b1);
            n_checks++;
            if (got_a !== exp) begin
                n_fail++;
                $display("FAIL pause_run_a cycle %0d: got %h required %h", cycle, got_a, exp);
            end
            if (got_a.sof) found = 1'b1;
        end
        n_checks++;
        if (!found || cycle - sof_cycle != 51) begin
            n_fail++;
            $display("FAIL sof_period_pause: got %0d (found=%0b) required 51", cycle - sof_cycle, found);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 100 && !(mh == 7 && mv == 2); i++) begin
            step(1'b1);
            n_checks++;
            if (got_a !== exp) begin
                n_fail++;
                $display("FAIL pre_reset_a cycle %0d: got %h required %h", cycle, got_a, exp);
            end
        end
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({hs_a, vs_a, de_a, sof_a, eol_a, x_a, y_a} !== 11'd0) begin
            n_fail++;
            $display("FAIL async_reset_a: got %h required %h", {hs_a, vs_a, de_a, sof_a, eol_a, x_a, y_a}, 11'd0);
        end
        n_checks++;
        if ({hs_b, vs_b, de_b, sof_b, eol_b, x_b, y_b} !== {2'b11, 9'd0}) begin
            n_fail++;
            $display("FAIL async_reset_b: got %h required %h", {hs_b, vs_b, de_b, sof_b, eol_b, x_b, y_b}, {2'b11, 9'd0});
        end
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            if (i == 0) begin
                n_checks++;
                if (got_a !== obs_t'{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0}) begin
                    n_fail++;
                    $display("FAIL restart_pixel: got %h required de=1 sof=1 x=0 y=0", got_a);
                end
            end
            n_checks++;
            if (got_a !== exp || got_b !== inv_pol(exp)) begin
                n_fail++;
                $display("FAIL restart_line cycle %0d: got a=%h b=%h required %h", cycle, got_a, got_b, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_hsync();
        test_frames();
        test_pause();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
